// File: rtl/gbuff_pkg.sv
// Shared types and index helpers for the banked global buffer.
package gbuff_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } gb_state_e;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_w(input int num_banks);
    return idx_w(num_banks);
  endfunction

  function automatic int row_w(input int depth, input int num_banks);
    return idx_w(depth / num_banks);
  endfunction

  // LSB of element idx inside a flattened vector of width-bit elements.
  function automatic int flat_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gbuff_bank_arb.sv
// Round-robin read arbiter for one bank; a write hitting the bank blocks every read.
module gbuff_bank_arb
  import gbuff_pkg::*;
#(
  parameter int NUM_RD = 3,
  parameter int PTR_W  = idx_w(NUM_RD)
) (
  input  logic [NUM_RD-1:0] req,
  input  logic              wr_hit,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_RD-1:0] grant,
  output logic [PTR_W-1:0]  ptr_next
);

  int idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = 0;
    if (!wr_hit) begin
      // Walk away from the pointer so the nearest requester is assigned last and wins.
      for (int k = NUM_RD - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NUM_RD;
        if (req[idx]) begin
          grant    = NUM_RD'(1) << idx;
          ptr_next = PTR_W'((idx + 1) % NUM_RD);
        end
      end
    end
  end

endmodule

// File: rtl/global_buffer_banked.sv
// Word-interleaved multi-bank scratchpad: one byte-strobed write port, NUM_RD read
// channels with per-bank round-robin arbitration, and a row-by-row clear sequencer.
module global_buffer_banked
  import gbuff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 256,
  parameter int NUM_BANKS = 4,
  parameter int NUM_RD    = 3,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic [WORD_W/8-1:0]      wr_strb,
  input  logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_resp_valid,
  output logic [NUM_RD*WORD_W-1:0] rd_data,
  input  logic                     clr_start,
  output logic                     clr_busy
);

  localparam int STRB_W     = WORD_W / 8;
  localparam int LOG2_BANKS = $clog2(NUM_BANKS);
  localparam int BANK_W     = bank_w(NUM_BANKS);
  localparam int ROWS       = DEPTH / NUM_BANKS;
  localparam int ROW_W      = row_w(DEPTH, NUM_BANKS);
  localparam int PTR_W      = idx_w(NUM_RD);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  gb_state_e         state_reg, state_next;
  logic [ROW_W-1:0]  row_cnt_reg, row_cnt_next;
  logic [WORD_W-1:0] mem [NUM_BANKS][ROWS];

  logic              active;
  logic              wr_fire;
  logic [BANK_W-1:0] wr_bank;
  logic [ROW_W-1:0]  wr_row;
  logic [BANK_W-1:0] rd_bank [NUM_RD];
  logic [ROW_W-1:0]  rd_row  [NUM_RD];

  logic [NUM_BANKS-1:0] wr_hit;
  logic [NUM_RD-1:0]    bank_req   [NUM_BANKS];
  logic [NUM_RD-1:0]    bank_grant [NUM_BANKS];
  logic [PTR_W-1:0]     ptr_reg    [NUM_BANKS];
  logic [PTR_W-1:0]     ptr_next   [NUM_BANKS];
  logic [NUM_RD-1:0]    rd_accept;

  logic [NUM_RD-1:0] resp_valid_reg;
  logic [WORD_W-1:0] rd_data_reg [NUM_RD];

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return BANK_W'(a & ADDR_W'(NUM_BANKS - 1));
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return ROW_W'(a >> LOG2_BANKS);
  endfunction

  // Handshakes only open in IDLE and are held shut while reset is asserted.
  assign active   = (state_reg == IDLE) && !rst;
  assign wr_ready = wr_valid && active;
  assign wr_fire  = wr_ready;
  assign clr_busy = (state_reg == CLEAR);

  always_comb begin
    wr_bank = bank_of(wr_addr);
    wr_row  = row_of(wr_addr);
    for (int c = 0; c < NUM_RD; c++) begin
      rd_bank[c] = bank_of(rd_addr[flat_lsb(c, ADDR_W) +: ADDR_W]);
      rd_row[c]  = row_of(rd_addr[flat_lsb(c, ADDR_W) +: ADDR_W]);
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_hit[b] = wr_fire && (wr_bank == BANK_W'(b));
      for (int c = 0; c < NUM_RD; c++) begin
        bank_req[b][c] = active && rd_valid[c] && (rd_bank[c] == BANK_W'(b));
      end
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_arb
    gbuff_bank_arb #(
      .NUM_RD (NUM_RD),
      .PTR_W  (PTR_W)
    ) u_arb (
      .req      (bank_req[gi]),
      .wr_hit   (wr_hit[gi]),
      .ptr      (ptr_reg[gi]),
      .grant    (bank_grant[gi]),
      .ptr_next (ptr_next[gi])
    );
  end

  always_comb begin
    rd_accept = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_accept = rd_accept | bank_grant[b];
    end
  end

  assign rd_ready = rd_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_reg[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_reg[b] <= ptr_next[b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next   = CLEAR;
          row_cnt_next = '0;
        end
      end
      CLEAR: begin
        row_cnt_next = row_cnt_reg + 1'b1;
        if (row_cnt_reg == LAST_ROW) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear and host writes never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[b][row_cnt_reg] <= '0;
      end
    end else if (wr_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) begin
          mem[wr_bank][wr_row][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= '0;
      for (int c = 0; c < NUM_RD; c++) begin
        rd_data_reg[c] <= '0;
      end
    end else begin
      resp_valid_reg <= rd_accept;
      for (int c = 0; c < NUM_RD; c++) begin
        if (rd_accept[c]) begin
          rd_data_reg[c] <= mem[rd_bank[c]][rd_row[c]];
        end
      end
    end
  end

  assign rd_resp_valid = resp_valid_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_out
    assign rd_data[gi*WORD_W +: WORD_W] = rd_data_reg[gi];
  end

endmodule

// File: tb/tb_global_buffer_banked.sv
// Bench for global_buffer_banked: directed vector table, clear/reset sequences and
// randomized traffic checked against an array-based reference model.
module tb_global_buffer_banked;

  localparam int WORD_W    = 32;
  localparam int DEPTH     = 256;
  localparam int NUM_BANKS = 4;
  localparam int NUM_RD    = 3;
  localparam int ADDR_W    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [2:0]  rd_valid, rd_ready, rd_resp_valid;
  logic [23:0] rd_addr;
  logic [95:0] rd_data;
  logic        clr_start, clr_busy;

  always #5 clk = ~clk;

  global_buffer_banked #(
    .WORD_W    (WORD_W),
    .DEPTH     (DEPTH),
    .NUM_BANKS (NUM_BANKS),
    .NUM_RD    (NUM_RD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_data       (rd_data),
    .clr_start     (clr_start),
    .clr_busy      (clr_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          rr [NUM_BANKS];
  logic        exp_wr_ready;
  logic [2:0]  exp_rd_ready;
  logic [31:0] exp_data [NUM_RD];

  typedef struct {
    logic            wv;
    logic [7:0]      wa;
    logic [31:0]     wd;
    logic [3:0]      ws;
    logic [2:0]      rv;
    logic [2:0][7:0] ra;
    logic            exp_wr;
    logic [2:0]      exp_rd;
    logic [2:0][31:0] exp_d;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [2:0] rv,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                              input logic ewr, input logic [2:0] erd,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.ws = ws; v.rv = rv;
    v.ra = {a2, a1, a0};
    v.exp_wr = ewr; v.exp_rd = erd;
    v.exp_d = {d2, d1, d0};
    return v;
  endfunction

  function automatic logic [7:0] ra(input int c);
    return rd_addr[c*8 +: 8];
  endfunction

  function automatic logic [31:0] rdat(input int c);
    return rd_data[c*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_valid = '0; rd_addr = '0; clr_start = 1'b0;
  endtask

  // Predict this cycle's handshakes and responses from the current inputs, then commit.
  task automatic model_predict();
    int c;
    exp_wr_ready = wr_valid;
    exp_rd_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_valid && (int'(wr_addr) % NUM_BANKS) == b) continue;
      for (int k = 0; k < NUM_RD; k++) begin
        c = (rr[b] + k) % NUM_RD;
        if (rd_valid[c] && (int'(ra(c)) % NUM_BANKS) == b) begin
          exp_rd_ready[c] = 1'b1;
          rr[b] = (c + 1) % NUM_RD;
          break;
        end
      end
    end
    for (int ch = 0; ch < NUM_RD; ch++) begin
      if (exp_rd_ready[ch]) exp_data[ch] = ref_mem[ra(ch)];
    end
    if (wr_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) ref_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  endtask

  task automatic drive_cycle(input string tag);
    model_predict();
    #1;
    check({tag, " wr_ready"}, 32'(wr_ready), 32'(exp_wr_ready));
    check({tag, " rd_ready"}, 32'(rd_ready), 32'(exp_rd_ready));
    @(posedge clk); #1;
    check({tag, " resp_valid"}, 32'(rd_resp_valid), 32'(exp_rd_ready));
    for (int c = 0; c < NUM_RD; c++) begin
      if (exp_rd_ready[c]) check($sformatf("%s rd_data%0d", tag, c), rdat(c), exp_data[c]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int ready_leak;
    logic [2:0] pend;

    foreach (rr[b]) rr[b] = 0;

    // Reset: all outputs low even with requests pending
    rst = 1'b1;
    idle();
    wr_valid = 1'b1; rd_valid = 3'b111;
    #12;
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    check("reset rd_ready", 32'(rd_ready), 32'd0);
    check("reset resp_valid", 32'(rd_resp_valid), 32'd0);
    check("reset clr_busy", 32'(clr_busy), 32'd0);
    for (int c = 0; c < NUM_RD; c++) check($sformatf("reset rd_data%0d", c), rdat(c), 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // wv wa wd ws | rv a0 a1 a2 | exp_wr exp_rd d0 d1 d2
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b001, 5, 0, 0,  0, 3'b001, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 9,  32'h11223344, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 9,  32'hAABBCCDD, 4'h5, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b010, 0, 9, 0,  0, 3'b010, 0, 32'h11BB33DD, 0));
    vecs.push_back(mk(1, 0,  32'h000000A0, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 4,  32'h000000A4, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 8,  32'h000000A8, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 1,  32'h000000B1, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1, 2,  32'h000000B2, 4'hF, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b111, 0, 4, 8,  0, 3'b001, 32'hA0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b111, 0, 4, 8,  0, 3'b010, 0, 32'hA4, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b111, 0, 4, 8,  0, 3'b100, 0, 0, 32'hA8));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b111, 0, 1, 2,  0, 3'b111, 32'hA0, 32'hB1, 32'hB2));
    vecs.push_back(mk(1, 12, 32'h00000C12, 4'hF, 3'b010, 0, 12, 0, 1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b010, 0, 12, 0, 0, 3'b010, 0, 32'hC12, 0));
    vecs.push_back(mk(1, 5,  32'hFFFFFFFF, 4'h0, 3'b000, 0, 0, 0,  1, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b100, 0, 0, 5,  0, 3'b100, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0,  0,            4'h0, 3'b000, 0, 0, 0,  0, 3'b000, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_strb = vecs[i].ws;
      rd_valid = vecs[i].rv; rd_addr = vecs[i].ra;
      model_predict();
      #1;
      check($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d rd_ready", i), 32'(rd_ready), 32'(vecs[i].exp_rd));
      @(posedge clk); #1;
      check($sformatf("vec%0d resp_valid", i), 32'(rd_resp_valid), 32'(vecs[i].exp_rd));
      for (int c = 0; c < NUM_RD; c++) begin
        if (vecs[i].exp_rd[c])
          check($sformatf("vec%0d rd_data%0d", i, c), rdat(c), vecs[i].exp_d[c]);
      end
      $display("vec %0d: wr=%b addr=%0d rd_valid=%b rd_ready=%b resp=%b data=%h",
               i, vecs[i].wv, vecs[i].wa, vecs[i].rv, rd_ready, rd_resp_valid, rd_data);
    end
    check("rd_data hold ch2", rdat(2), 32'hDEADBEEF);

    // Fill with addr+1, then start a clear in the same cycle as a write and a read
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      wr_valid = 1'b1; wr_addr = 8'(a); wr_data = 32'(a + 1); wr_strb = 4'hF;
      drive_cycle("fill");
    end
    idle();
    wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 32'h3333; wr_strb = 4'hF;
    rd_valid = 3'b001; rd_addr = 24'd7; clr_start = 1'b1;
    drive_cycle("clr+wr+rd");
    $display("clear started: wr_ready=%b rd_resp=%b data0=%h", exp_wr_ready, rd_resp_valid, rdat(0));

    // Hold requests (and a re-pulse of clr_start) during the clear; nothing may be accepted
    idle();
    wr_valid = 1'b1; rd_valid = 3'b111; rd_addr = {8'd2, 8'd1, 8'd0}; clr_start = 1'b1;
    busy = 0; ready_leak = 0;
    #2;
    while (clr_busy === 1'b1 && busy < 200) begin
      busy++;
      if (wr_ready !== 1'b0 || rd_ready !== 3'b000) ready_leak++;
      if (busy >= 30) clr_start = 1'b0;
      @(posedge clk); #2;
    end
    idle();
    check("clear busy cycles", 32'(busy), 32'd64);
    check("ready during clear", 32'(ready_leak), 32'd0);
    $display("clear done: busy_cycles=%0d", busy);
    foreach (ref_mem[a]) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_valid = 3'b001; rd_addr = {16'd0, 8'(a)};
      drive_cycle("post-clear read");
    end

    // Randomized traffic; stalled channels hold their request
    idle();
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 8'($urandom_range(0, 31));
      wr_data  = $urandom;
      wr_strb  = 4'($urandom_range(0, 15));
      for (int c = 0; c < NUM_RD; c++) begin
        if (!pend[c]) begin
          rd_valid[c] = 1'($urandom_range(0, 1));
          rd_addr[c*8 +: 8] = 8'($urandom_range(0, 31));
        end
      end
      drive_cycle($sformatf("rand%0d", n));
      pend = rd_valid & ~exp_rd_ready;
      $display("rand %0d: wr=%b@%0d rd_valid=%b addr=%h granted=%b data=%h",
               n, wr_valid, wr_addr, rd_valid, rd_addr, exp_rd_ready, rd_data);
    end
    idle();

    // Async reset in the middle of a clear (row_cnt = 20)
    for (int a = 0; a < DEPTH; a++) begin
      wr_valid = 1'b1; wr_addr = 8'(a); wr_data = 32'(a + 1); wr_strb = 4'hF;
      drive_cycle("refill");
    end
    idle();
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("busy before reset", 32'(clr_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset clr_busy", 32'(clr_busy), 32'd0);
    check("async reset resp_valid", 32'(rd_resp_valid), 32'd0);
    for (int c = 0; c < NUM_RD; c++) check($sformatf("async reset rd_data%0d", c), rdat(c), 32'd0);
    $display("reset mid-clear: clr_busy=%b resp=%b", clr_busy, rd_resp_valid);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (rr[b]) rr[b] = 0;
    foreach (ref_mem[a]) ref_mem[a] = (a < 20 * NUM_BANKS) ? 32'd0 : 32'(a + 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_valid = 3'b001 << (a % NUM_RD);
      rd_addr  = 24'(a) << (8 * (a % NUM_RD));
      drive_cycle("partial-clear read");
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/global_buffer_banked.md
Name: global_buffer_banked

Overview:
Next-generation TPU global buffer. A parametrised, multi-bank, word-interleaved scratchpad with one write channel and NUM_RD independent read channels, so the A-, B- and partial-sum feeders of the systolic array can access it concurrently. Per-bank conflict arbitration uses valid/ready handshakes and byte-strobe writes. A counter-driven clear sequencer replaces the old reset-time array clear. Sits between the host/DMA loader and the PE-array feeders.

Parameters:
WORD_W, 32, data word width in bits (multiple of 8)
DEPTH, 256, total words (power of 2, ≥ NUM_BANKS)
NUM_BANKS, 4, number of interleaved banks (power of 2)
NUM_RD, 3, number of read channels
ADDR_W, $clog2(DEPTH), word address width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
wr_addr  in  ADDR_W  write word address
wr_data  in  WORD_W  write data
wr_strb  in  WORD_W/8  byte enables, bit i covers data[8i+7:8i]
rd_valid  in  NUM_RD  per-channel read request
rd_ready  out  NUM_RD  per-channel accept
rd_addr  in  NUM_RD*ADDR_W  flattened addresses, channel c at [c*ADDR_W +: ADDR_W]
rd_resp_valid  out  NUM_RD  response strobe
rd_data  out  NUM_RD*WORD_W  flattened read data
clr_start  in  1  pulse: start zeroing the whole buffer
clr_busy  out  1  high while clear is in progress

Behaviour:
- Mapping: bank = addr[log2(NUM_BANKS)-1:0]; row = addr >> log2(NUM_BANKS). Each bank serves at most one access per cycle.
- Reset (async): wr_ready=0, rd_ready=0, rd_resp_valid=0, rd_data=0, clr_busy=0, all round-robin pointers=0, FSM=IDLE. Memory contents are not reset; software uses clear.
- FSM IDLE:
  - wr_ready=1 whenever wr_valid is high.
  - A write goes to its bank and has absolute priority over reads to that bank.
  - Reads are arbitrated per bank among the channels targeting it, excluding a bank taken by the write.
  - The winner gets rd_ready=1. Losers see rd_ready=0 and must hold valid/addr stable until accepted.
- Round robin: one pointer per bank. After a grant to channel c, that bank's pointer moves to c+1 mod NUM_RD. The pointer does not move without a grant.
- Read latency: exactly 1 cycle. rd_resp_valid[c] and rd_data[c] update on the clk edge after acceptance. There is no response backpressure. rd_resp_valid is a single-cycle pulse per accept, and rd_data holds its value between responses.
- Same-cycle write and read to the same address: the read is stalled that cycle and returns the new data when granted later. There is never a read-during-write hazard.
- Byte-strobe write: only bytes with wr_strb=1 change. wr_strb=0 with wr_valid=1 is still accepted as a no-op handshake.
- Clear:
  - clr_start in IDLE moves to CLEAR. row_cnt=0 and clr_busy=1 on the next edge.
  - Each cycle, row row_cnt of every bank is written to 0, then row_cnt++.
  - After row DEPTH/NUM_BANKS-1 the FSM returns to IDLE and clr_busy drops. The clear lasts DEPTH/NUM_BANKS cycles.
  - During CLEAR, wr_ready=0 and rd_ready=0. Responses already in flight still complete.
  - clr_start while busy is ignored.
  - If clr_start, wr_valid and rd_valid are all asserted in IDLE on the same cycle, the write and the granted reads are serviced that cycle and the clear starts next cycle.
- Reset mid-clear: the clear is aborted immediately (FSM=IDLE). Memory is left partially cleared; this is legal.
- ready signals are combinational from valid/addr/FSM state. There is no combinational path from any input to rd_data.

Decomposition:
- Package gbuff_pkg: FSM state enum {IDLE, CLEAR}, bank-index and row-index width functions, and a flatten/unflatten index helper.
- Sub-module gbuff_bank_arb, instantiated once per bank: inputs are the per-channel request-hits-this-bank vector and a write-hit bit; outputs are a one-hot grant and the pointer update.
- Bank storage is an inferred array inside the top, with per-byte write masking.

Test Plan:
- Write 0xDEADBEEF to addr 5 with strb=4'hF, then read on channel 0 → next cycle rd_resp_valid[0]=1 and rd_data[0]=0xDEADBEEF.
- Strobe merge: write 0x11223344 to addr 9, then write 0xAABBCCDD with strb=4'b0101 → read returns 0x11BB33DD.
- Conflict: channels 0, 1 and 2 read addrs 0, 4 and 8 (all bank 0) continuously for 3 cycles → grants go ch0, ch1, ch2 in order; with no conflict (addrs 0, 1, 2) all three are granted in the same cycle.
- Write priority: wr to addr 12 and ch1 read of addr 12 in the same cycle → wr_ready=1, rd_ready[1]=0; next cycle ch1 is granted and returns the newly written data.
- Clear: fill all 256 words with the value addr+1 and pulse clr_start → clr_busy high for exactly 64 cycles and all ready=0 during it; afterwards every address reads 0.
- Async reset asserted mid-clear (row_cnt=20) → clr_busy=0 and rd_resp_valid=0 immediately without a clock edge; after release, rows ≥20 still hold their old data.
